// File: rtl/test_result_monitor_pkg.sv
// Shared constants and types for the end-of-test monitor and the per-test bench wrappers.
// Holds the end address, the gp register index and the pass encoding in one place.
package test_result_monitor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } mon_state_e;

  localparam logic [4:0]  GP_REG         = 5'd3;
  localparam logic [31:0] PASS_GP        = 32'h0000_0001;
  localparam logic [31:0] DEFAULT_END_PC = 32'h0000_0044;

  typedef struct packed {
    logic        pass;
    logic        fail;
    logic [30:0] testnum;
  } verdict_t;

  // riscv-tests encode gp = testnum<<1 | 1; only gp==1 is a pass.
  function automatic verdict_t eval_gp(input logic [31:0] gp);
    verdict_t v;
    v.pass    = (gp == PASS_GP);
    v.fail    = (gp != PASS_GP);
    v.testnum = (gp == PASS_GP) ? 31'd0 : gp[31:1];
    return v;
  endfunction

endpackage

// File: rtl/test_result_monitor_if.sv
// Observation/status bundle between the core side and the end-of-test monitor.
interface test_result_monitor_if #(
  parameter int CNT_W = 32
);
  logic              start;
  logic [31:0]       if_pc;
  logic              if_valid;
  logic              wb_we;
  logic [4:0]        wb_rd;
  logic [31:0]       wb_data;
  logic              busy;
  logic              done;
  logic              pass;
  logic              fail;
  logic              timeout;
  logic [30:0]       fail_testnum;
  logic [CNT_W-1:0]  cycle_count;

  modport master (
    output start, if_pc, if_valid, wb_we, wb_rd, wb_data,
    input  busy, done, pass, fail, timeout, fail_testnum, cycle_count
  );

  modport slave (
    input  start, if_pc, if_valid, wb_we, wb_rd, wb_data,
    output busy, done, pass, fail, timeout, fail_testnum, cycle_count
  );
endinterface

// File: rtl/test_result_monitor_sat_counter.sv
// Up-counter with synchronous clear and enable that sticks at all-ones.
module test_result_monitor_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en && (q != '1)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/test_result_monitor.sv
// End-of-test checker: shadows gp, waits for END_PC, drains the pipeline and latches
// a sticky pass/fail/timeout verdict with the failing test number and cycle count.
module test_result_monitor
  import test_result_monitor_pkg::*;
#(
  parameter logic [31:0] END_PC         = DEFAULT_END_PC,
  parameter int          DRAIN_CYCLES   = 4,
  parameter int          TIMEOUT_CYCLES = 6000,
  parameter int          CNT_W          = 32
) (
  input logic                  clk,
  input logic                  rst,
  test_result_monitor_if.slave mon
);

  // state | meaning
  // IDLE  | waiting for start, all inputs ignored
  // RUN   | counting cycles, tracking gp, looking for END_PC
  // DRAIN | END_PC seen, letting in-flight writebacks land
  // DONE  | verdict latched and held until the next start

  localparam int DW = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;

  mon_state_e        state, state_nx;
  logic [31:0]       gp, gp_nx;
  logic [DW-1:0]     drain_cnt;
  logic              start_ok;
  logic              end_hit;
  logic              timeout_hit;
  logic              tracking;
  verdict_t          verdict;

  logic              busy_q, done_q, pass_q, fail_q, timeout_q;
  logic [30:0]       testnum_q;
  logic              busy_nx, done_nx, pass_nx, fail_nx, timeout_nx;
  logic [30:0]       testnum_nx;

  assign tracking    = (state == ST_RUN) || (state == ST_DRAIN);
  assign start_ok    = mon.start && ((state == ST_IDLE) || (state == ST_DONE));
  assign end_hit     = mon.if_valid && (mon.if_pc == END_PC);
  assign timeout_hit = (mon.cycle_count == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    gp_nx = gp;
    if (start_ok) begin
      gp_nx = '0;
    end else if (tracking && mon.wb_we && (mon.wb_rd == GP_REG)) begin
      gp_nx = mon.wb_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      gp        <= '0;
      drain_cnt <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      fail_q    <= 1'b0;
      timeout_q <= 1'b0;
      testnum_q <= '0;
    end else begin
      state <= state_nx;
      gp    <= gp_nx;
      if ((state == ST_RUN) && end_hit) begin
        drain_cnt <= DW'(DRAIN_CYCLES);
      end else if ((state == ST_DRAIN) && (drain_cnt != '0)) begin
        drain_cnt <= drain_cnt - DW'(1);
      end
      busy_q    <= busy_nx;
      done_q    <= done_nx;
      pass_q    <= pass_nx;
      fail_q    <= fail_nx;
      timeout_q <= timeout_nx;
      testnum_q <= testnum_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (mon.start) state_nx = ST_RUN;
      // a valid END_PC fetch wins over a timeout on the same cycle
      ST_RUN: begin
        if (end_hit) begin
          state_nx = ST_DRAIN;
        end else if (timeout_hit) begin
          state_nx = ST_DONE;
        end
      end
      ST_DRAIN: if (drain_cnt == '0) state_nx = ST_DONE;
      ST_DONE:  if (mon.start) state_nx = ST_RUN;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    verdict    = eval_gp(gp_nx);
    busy_nx    = (state_nx == ST_RUN) || (state_nx == ST_DRAIN);
    done_nx    = done_q;
    pass_nx    = pass_q;
    fail_nx    = fail_q;
    timeout_nx = timeout_q;
    testnum_nx = testnum_q;
    if (start_ok) begin
      done_nx    = 1'b0;
      pass_nx    = 1'b0;
      fail_nx    = 1'b0;
      timeout_nx = 1'b0;
      testnum_nx = '0;
    end else if ((state == ST_RUN) && !end_hit && timeout_hit) begin
      done_nx    = 1'b1;
      timeout_nx = 1'b1;
    end else if ((state == ST_DRAIN) && (drain_cnt == '0)) begin
      // gp_nx so a write landing in the final drain cycle counts
      done_nx    = 1'b1;
      pass_nx    = verdict.pass;
      fail_nx    = verdict.fail;
      testnum_nx = verdict.testnum;
    end
  end

  test_result_monitor_sat_counter #(
    .W (CNT_W)
  ) u_cycle_cnt (
    .clk (clk),
    .rst (rst),
    .clr (start_ok),
    .en  (tracking),
    .q   (mon.cycle_count)
  );

  assign mon.busy         = busy_q;
  assign mon.done         = done_q;
  assign mon.pass         = pass_q;
  assign mon.fail         = fail_q;
  assign mon.timeout      = timeout_q;
  assign mon.fail_testnum = testnum_q;

endmodule

// File: tb/tb_test_result_monitor.sv
// Directed bench: three monitors (default, short timeout, zero drain) share one stimulus.
module tb_test_result_monitor;
  import test_result_monitor_pkg::*;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] if_pc;
  logic        if_valid;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int total;
  int bad;

  test_result_monitor_if #(.CNT_W(32)) m  ();
  test_result_monitor_if #(.CNT_W(32)) mt ();
  test_result_monitor_if #(.CNT_W(32)) mz ();

  assign m.start  = start;  assign m.if_pc  = if_pc;  assign m.if_valid  = if_valid;
  assign m.wb_we  = wb_we;  assign m.wb_rd  = wb_rd;  assign m.wb_data   = wb_data;
  assign mt.start = start;  assign mt.if_pc = if_pc;  assign mt.if_valid = if_valid;
  assign mt.wb_we = wb_we;  assign mt.wb_rd = wb_rd;  assign mt.wb_data  = wb_data;
  assign mz.start = start;  assign mz.if_pc = if_pc;  assign mz.if_valid = if_valid;
  assign mz.wb_we = wb_we;  assign mz.wb_rd = wb_rd;  assign mz.wb_data  = wb_data;

  test_result_monitor #(.END_PC(DEFAULT_END_PC), .DRAIN_CYCLES(4), .TIMEOUT_CYCLES(6000), .CNT_W(32))
    dut (.clk(clk), .rst(rst), .mon(m));
  test_result_monitor #(.END_PC(DEFAULT_END_PC), .DRAIN_CYCLES(4), .TIMEOUT_CYCLES(50), .CNT_W(32))
    dut_to (.clk(clk), .rst(rst), .mon(mt));
  test_result_monitor #(.END_PC(DEFAULT_END_PC), .DRAIN_CYCLES(0), .TIMEOUT_CYCLES(6000), .CNT_W(32))
    dut_z (.clk(clk), .rst(rst), .mon(mz));

  // {busy, done, pass, fail, timeout}
  logic [4:0] mf, tf, zf;
  assign mf = {m.busy,  m.done,  m.pass,  m.fail,  m.timeout};
  assign tf = {mt.busy, mt.done, mt.pass, mt.fail, mt.timeout};
  assign zf = {mz.busy, mz.done, mz.pass, mz.fail, mz.timeout};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic write_reg(input logic [4:0] rd, input logic [31:0] d);
    wb_we = 1'b1; wb_rd = rd; wb_data = d;
    tick(1);
    wb_we = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
  endtask

  task automatic fetch(input logic [31:0] pc, input logic v);
    if_pc = pc; if_valid = v;
    tick(1);
    if_pc = 32'd0; if_valid = 1'b0;
  endtask

  task automatic test_reset;
    total++; if (mf !== 5'b00000) begin bad++; $display("FAIL reset_flags: got %b want 00000", mf); end
    total++; if (m.cycle_count !== 32'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", m.cycle_count); end
    total++; if (m.fail_testnum !== 31'd0) begin bad++; $display("FAIL reset_testnum: got %0d want 0", m.fail_testnum); end
    total++; if ({tf, zf} !== 10'd0) begin bad++; $display("FAIL reset_flags_others: got %b want 0", {tf, zf}); end
  endtask

  task automatic test_pass;
    pulse_start();
    total++; if (mf !== 5'b10000) begin bad++; $display("FAIL pass_start_flags: got %b want 10000", mf); end
    total++; if (m.cycle_count !== 32'd0) begin bad++; $display("FAIL pass_start_count: got %0d want 0", m.cycle_count); end
    write_reg(5'd3, 32'd2);
    write_reg(5'd3, 32'd4);
    write_reg(5'd3, 32'd1);
    pulse_start();
    total++; if (m.cycle_count !== 32'd4) begin bad++; $display("FAIL start_in_run_ignored: got %0d want 4", m.cycle_count); end
    tick(95);
    fetch(DEFAULT_END_PC, 1'b1);
    total++; if (mf !== 5'b10000) begin bad++; $display("FAIL pass_drain_flags: got %b want 10000", mf); end
    tick(1);
    total++; if (zf !== 5'b01100) begin bad++; $display("FAIL zero_drain_flags: got %b want 01100", zf); end
    total++; if (mz.cycle_count !== 32'd101) begin bad++; $display("FAIL zero_drain_count: got %0d want 101", mz.cycle_count); end
    tick(3);
    total++; if (mf !== 5'b10000) begin bad++; $display("FAIL pass_early_flags: got %b want 10000", mf); end
    tick(1);
    total++; if (mf !== 5'b01100) begin bad++; $display("FAIL pass_flags: got %b want 01100", mf); end
    total++; if (m.cycle_count !== 32'd105) begin bad++; $display("FAIL pass_count: got %0d want 105", m.cycle_count); end
    total++; if (m.fail_testnum !== 31'd0) begin bad++; $display("FAIL pass_testnum: got %0d want 0", m.fail_testnum); end
    total++; if (tf !== 5'b01001) begin bad++; $display("FAIL short_timeout_flags: got %b want 01001", tf); end
    total++; if (mt.cycle_count !== 32'd50) begin bad++; $display("FAIL short_timeout_count: got %0d want 50", mt.cycle_count); end
  endtask

  task automatic test_fail_restart;
    pulse_start();
    total++; if (mf !== 5'b10000) begin bad++; $display("FAIL restart_flags: got %b want 10000", mf); end
    total++; if ({m.cycle_count, m.fail_testnum} !== 63'd0) begin bad++; $display("FAIL restart_cleared: count=%0d testnum=%0d want 0", m.cycle_count, m.fail_testnum); end
    write_reg(5'd3, 32'h0000_0009);
    write_reg(5'd0, 32'h0000_0001);
    write_reg(5'd4, 32'h0000_0001);
    fetch(DEFAULT_END_PC, 1'b0);
    fetch(DEFAULT_END_PC, 1'b1);
    tick(1);
    total++; if (zf !== 5'b01010 || mz.fail_testnum !== 31'd4) begin bad++; $display("FAIL zero_drain_fail: got %b/%0d want 01010/4", zf, mz.fail_testnum); end
    tick(3);
    total++; if (mf !== 5'b10000) begin bad++; $display("FAIL fail_early_flags: got %b want 10000", mf); end
    tick(1);
    total++; if (mf !== 5'b01010) begin bad++; $display("FAIL fail_flags: got %b want 01010", mf); end
    total++; if (m.fail_testnum !== 31'd4) begin bad++; $display("FAIL fail_testnum: got %0d want 4", m.fail_testnum); end
    total++; if (m.cycle_count !== 32'd10) begin bad++; $display("FAIL fail_count: got %0d want 10", m.cycle_count); end
    write_reg(5'd3, 32'h0000_0001);
    fetch(DEFAULT_END_PC, 1'b1);
    total++; if (mf !== 5'b01010 || m.fail_testnum !== 31'd4 || m.cycle_count !== 32'd10) begin
      bad++; $display("FAIL done_hold: got %b/%0d/%0d want 01010/4/10", mf, m.fail_testnum, m.cycle_count);
    end
  endtask

  task automatic test_late_writeback;
    pulse_start();
    write_reg(5'd3, 32'h0000_0009);
    fetch(DEFAULT_END_PC, 1'b1);
    tick(2);
    write_reg(5'd3, 32'h0000_0001);
    tick(2);
    total++; if (mf !== 5'b01100 || m.cycle_count !== 32'd7) begin bad++; $display("FAIL late_wb_pass: got %b/%0d want 01100/7", mf, m.cycle_count); end
    total++; if (zf !== 5'b01010 || mz.fail_testnum !== 31'd4 || mz.cycle_count !== 32'd3) begin
      bad++; $display("FAIL late_wb_after_verdict: got %b/%0d/%0d want 01010/4/3", zf, mz.fail_testnum, mz.cycle_count);
    end
  endtask

  task automatic test_final_drain_write;
    pulse_start();
    write_reg(5'd3, 32'h0000_0009);
    fetch(DEFAULT_END_PC, 1'b1);
    tick(4);
    total++; if (mf !== 5'b10000) begin bad++; $display("FAIL final_drain_busy: got %b want 10000", mf); end
    write_reg(5'd3, 32'h0000_0001);
    total++; if (mf !== 5'b01100 || m.fail_testnum !== 31'd0 || m.cycle_count !== 32'd7) begin
      bad++; $display("FAIL final_drain_pass: got %b/%0d/%0d want 01100/0/7", mf, m.fail_testnum, m.cycle_count);
    end
  endtask

  task automatic test_match_at_timeout;
    pulse_start();
    tick(49);
    fetch(DEFAULT_END_PC, 1'b1);
    total++; if (tf !== 5'b10000 || mt.cycle_count !== 32'd50) begin bad++; $display("FAIL match_wins_drain: got %b/%0d want 10000/50", tf, mt.cycle_count); end
    tick(5);
    total++; if (tf !== 5'b01010 || mt.fail_testnum !== 31'd0 || mt.cycle_count !== 32'd55) begin
      bad++; $display("FAIL match_wins_verdict: got %b/%0d/%0d want 01010/0/55", tf, mt.fail_testnum, mt.cycle_count);
    end
  endtask

  task automatic test_timeout;
    pulse_start();
    if_pc = DEFAULT_END_PC; if_valid = 1'b0;
    tick(49);
    total++; if (tf !== 5'b10000 || mt.cycle_count !== 32'd49) begin bad++; $display("FAIL timeout_early: got %b/%0d want 10000/49", tf, mt.cycle_count); end
    tick(1);
    total++; if (tf !== 5'b01001) begin bad++; $display("FAIL timeout_flags: got %b want 01001", tf); end
    total++; if (mt.cycle_count !== 32'd50 || mt.fail_testnum !== 31'd0) begin bad++; $display("FAIL timeout_count: got %0d/%0d want 50/0", mt.cycle_count, mt.fail_testnum); end
    tick(3);
    total++; if (tf !== 5'b01001 || mt.cycle_count !== 32'd50) begin bad++; $display("FAIL timeout_hold: got %b/%0d want 01001/50", tf, mt.cycle_count); end
    if_pc = 32'd0;
  endtask

  task automatic test_reset_mid_drain;
    fetch(DEFAULT_END_PC, 1'b1);
    tick(2);
    total++; if (mf !== 5'b10000) begin bad++; $display("FAIL pre_reset_drain: got %b want 10000", mf); end
    #3 rst = 1'b1;
    #1;
    total++; if ({mf, tf, zf} !== 15'd0) begin bad++; $display("FAIL async_reset_flags: got %b want 0", {mf, tf, zf}); end
    total++; if (m.cycle_count !== 32'd0) begin bad++; $display("FAIL async_reset_count: got %0d want 0", m.cycle_count); end
    #2 rst = 1'b0;
    tick(1);
    fetch(DEFAULT_END_PC, 1'b1);
    write_reg(5'd3, 32'h0000_0001);
    tick(6);
    total++; if (mf !== 5'b00000 || m.cycle_count !== 32'd0) begin bad++; $display("FAIL idle_ignores: got %b/%0d want 00000/0", mf, m.cycle_count); end
    pulse_start();
    write_reg(5'd3, 32'h0000_0001);
    fetch(DEFAULT_END_PC, 1'b1);
    tick(5);
    total++; if (mf !== 5'b01100 || m.cycle_count !== 32'd7) begin bad++; $display("FAIL post_reset_pass: got %b/%0d want 01100/7", mf, m.cycle_count); end
    total++; if (tf !== 5'b01100 || mt.cycle_count !== 32'd7) begin bad++; $display("FAIL post_reset_pass_to: got %b/%0d want 01100/7", tf, mt.cycle_count); end
    total++; if (zf !== 5'b01100 || mz.cycle_count !== 32'd3) begin bad++; $display("FAIL post_reset_pass_zero: got %b/%0d want 01100/3", zf, mz.cycle_count); end
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b1; start = 1'b0; if_pc = 32'd0; if_valid = 1'b0;
    wb_we = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
    #3;
    test_reset();
    #5 rst = 1'b0;
    tick(1);
    test_pass();
    test_fail_restart();
    test_late_writeback();
    test_final_drain_write();
    test_match_at_timeout();
    test_timeout();
    test_reset_mid_drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
